// File: rtl/board_editor_pkg.sv
// Board geometry, word packing and the cell decode shared by the renderer fetch
// path and the editor, so both sides map (x,y) to the same word and bit.
package board_editor_pkg;

  localparam int WORD_SIZE      = 16;
  localparam int LOG_WORD_SIZE  = 4;
  localparam int BOARD_SIZE     = 64;
  localparam int LOG_BOARD_SIZE = 6;
  localparam int WORDS_PER_ROW  = BOARD_SIZE / WORD_SIZE;
  localparam int LOG_MAX_ADDR   = $clog2(BOARD_SIZE * BOARD_SIZE / WORD_SIZE);

  typedef logic [LOG_BOARD_SIZE-1:0] pos_t;
  typedef logic [LOG_MAX_ADDR-1:0]   addr_t;
  typedef logic [WORD_SIZE-1:0]      word_t;
  typedef logic [LOG_WORD_SIZE-1:0]  bit_t;

  function automatic addr_t cell_addr(input pos_t x, input pos_t y);
    addr_t ya;
    addr_t xa;
    ya = addr_t'(y);
    xa = addr_t'(x >> LOG_WORD_SIZE);
    return ya * addr_t'(WORDS_PER_ROW) + xa;
  endfunction

  // MSB holds the leftmost cell of the word.
  function automatic bit_t cell_bit(input pos_t x);
    return LOG_WORD_SIZE'(WORD_SIZE - 1) - x[LOG_WORD_SIZE-1:0];
  endfunction

endpackage

// File: rtl/board_editor_if.sv
// Request, cursor and board-memory port bundle between the input logic,
// the editor and the board memory.
interface board_editor_if;
  import board_editor_pkg::*;

  logic  toggle_in;
  logic  clear_in;
  pos_t  cursor_x_in;
  pos_t  cursor_y_in;
  word_t data_r_in;
  addr_t addr_r_out;
  addr_t addr_w_out;
  word_t data_w_out;
  logic  wr_en_out;
  logic  busy_out;
  logic  done_out;

  modport slave (
    input  toggle_in, clear_in, cursor_x_in, cursor_y_in, data_r_in,
    output addr_r_out, addr_w_out, data_w_out, wr_en_out, busy_out, done_out
  );

  modport master (
    output toggle_in, clear_in, cursor_x_in, cursor_y_in, data_r_in,
    input  addr_r_out, addr_w_out, data_w_out, wr_en_out, busy_out, done_out
  );

endinterface

// File: rtl/board_editor.sv
// Read-modify-write engine on the board memory: toggles the cell under the
// cursor, or sweeps zeros over every word on a clear request.
module board_editor
  import board_editor_pkg::*;
#(
  parameter int READ_LATENCY = 2,
  parameter int NUM_WORDS    = BOARD_SIZE * BOARD_SIZE / WORD_SIZE
) (
  input  logic             clk_in,
  input  logic             rst_in,
  board_editor_if.slave    bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_WRITE,
    S_CLEAR,
    S_DONE
  } state_t;

  state_t r_state;
  addr_t  r_cnt;
  bit_t   r_bit;
  addr_t  r_addr_r;
  addr_t  r_addr_w;
  word_t  r_data_w;
  logic   r_wr_en;
  logic   r_busy;
  logic   r_done;

  addr_t  w_cur_addr;
  bit_t   w_cur_bit;
  word_t  w_mask;

  always_comb begin
    w_cur_addr = cell_addr(bus.cursor_x_in, bus.cursor_y_in);
    w_cur_bit  = cell_bit(bus.cursor_x_in);
    w_mask     = word_t'(1) << r_bit;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_bit    <= '0;
      r_addr_r <= '0;
      r_addr_w <= '0;
      r_data_w <= '0;
      r_wr_en  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.clear_in) begin
            r_state  <= S_CLEAR;
            r_cnt    <= '0;
            r_addr_w <= '0;
            r_data_w <= '0;
            r_wr_en  <= 1'b1;
            r_busy   <= 1'b1;
          end else if (bus.toggle_in) begin
            // The read address doubles as the latched cell address for the write.
            r_state  <= S_READ;
            r_addr_r <= w_cur_addr;
            r_bit    <= w_cur_bit;
            r_busy   <= 1'b1;
          end
        end
        S_READ: begin
          r_cnt   <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (r_cnt == addr_t'(READ_LATENCY - 1)) begin
            r_cnt    <= '0;
            r_addr_w <= r_addr_r;
            r_data_w <= bus.data_r_in ^ w_mask;
            r_wr_en  <= 1'b1;
            r_state  <= S_WRITE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_WRITE: begin
          r_wr_en <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end
        S_CLEAR: begin
          if (r_cnt == addr_t'(NUM_WORDS - 1)) begin
            r_cnt   <= '0;
            r_wr_en <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_cnt    <= r_cnt + 1'b1;
            r_addr_w <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.addr_r_out = r_addr_r;
  assign bus.addr_w_out = r_addr_w;
  assign bus.data_w_out = r_data_w;
  assign bus.wr_en_out  = r_wr_en;
  assign bus.busy_out   = r_busy;
  assign bus.done_out   = r_done;

endmodule

// File: tb/tb_board_editor.sv
// Directed bench for board_editor against a 2-cycle-latency behavioural board memory.
module tb_board_editor;
  import board_editor_pkg::*;

  localparam int NW = BOARD_SIZE * BOARD_SIZE / WORD_SIZE;

  logic clk = 1'b0;
  logic rst;

  board_editor_if bus();

  board_editor #(.READ_LATENCY(2), .NUM_WORDS(NW)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  word_t mem [NW];
  word_t rd_p1;
  logic  fill_req = 1'b0;
  int    fill_mode = 0;
  logic  poke_en = 1'b0;
  addr_t poke_addr = '0;
  word_t poke_data = '0;
  int    n_wr = 0;
  int    n_done = 0;
  int    n_checks = 0;
  int    n_errors = 0;

  function automatic word_t fill_val(input int mode, input int i);
    case (mode)
      1:       return word_t'(32'hA5C3 ^ (i * 32'h1357));
      2:       return 16'hFFFF;
      default: return 16'h0000;
    endcase
  endfunction

  always @(posedge clk) begin
    rd_p1         <= mem[bus.addr_r_out];
    bus.data_r_in <= rd_p1;
    if (fill_req) begin
      for (int i = 0; i < NW; i++) mem[i] <= fill_val(fill_mode, i);
    end else if (poke_en) begin
      mem[poke_addr] <= poke_data;
    end
    if (bus.wr_en_out) begin
      mem[bus.addr_w_out] <= bus.data_w_out;
      n_wr <= n_wr + 1;
    end
    if (bus.done_out) n_done <= n_done + 1;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic fill(input int mode);
    fill_mode = mode;
    fill_req  = 1'b1;
    @(negedge clk);
    fill_req  = 1'b0;
  endtask

  task automatic poke(input int a, input word_t d);
    poke_addr = addr_t'(a);
    poke_data = d;
    poke_en   = 1'b1;
    @(negedge clk);
    poke_en   = 1'b0;
  endtask

  // One-cycle request pulse; returns at the first negedge after acceptance.
  task automatic issue(input logic tog, input logic clr, input int x, input int y);
    bus.cursor_x_in = pos_t'(x);
    bus.cursor_y_in = pos_t'(y);
    bus.toggle_in   = tog;
    bus.clear_in    = clr;
    @(negedge clk);
    bus.toggle_in   = 1'b0;
    bus.clear_in    = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step(2);
    n_checks++; if (bus.addr_r_out !== 8'd0) begin n_errors++; $display("FAIL rst_addr_r: got %h want 00", bus.addr_r_out); end
    n_checks++; if (bus.addr_w_out !== 8'd0) begin n_errors++; $display("FAIL rst_addr_w: got %h want 00", bus.addr_w_out); end
    n_checks++; if (bus.data_w_out !== 16'h0) begin n_errors++; $display("FAIL rst_data_w: got %h want 0000", bus.data_w_out); end
    n_checks++; if ({bus.wr_en_out, bus.busy_out, bus.done_out} !== 3'b000) begin n_errors++; $display("FAIL rst_ctrl: got %b want 000", {bus.wr_en_out, bus.busy_out, bus.done_out}); end
    rst = 1'b0;
    step(1);
  endtask

  task automatic test_toggle_origin;
    int w0, d0;
    fill(0);
    w0 = n_wr; d0 = n_done;
    issue(1'b1, 1'b0, 0, 0);
    n_checks++; if (bus.addr_r_out !== 8'd0) begin n_errors++; $display("FAIL org_addr_r: got %h want 00", bus.addr_r_out); end
    n_checks++; if ({bus.busy_out, bus.wr_en_out} !== 2'b10) begin n_errors++; $display("FAIL org_busy_t1: got %b want 10", {bus.busy_out, bus.wr_en_out}); end
    step(2);
    n_checks++; if (bus.wr_en_out !== 1'b0) begin n_errors++; $display("FAIL org_early_wr: got %b want 0", bus.wr_en_out); end
    step(1);
    n_checks++; if ({bus.wr_en_out, bus.addr_w_out, bus.data_w_out, bus.done_out} !== {1'b1, 8'd0, 16'h8000, 1'b0}) begin
      n_errors++; $display("FAIL org_write_t4: got wr=%b a=%h d=%h done=%b want wr=1 a=00 d=8000 done=0", bus.wr_en_out, bus.addr_w_out, bus.data_w_out, bus.done_out); end
    step(1);
    n_checks++; if ({bus.done_out, bus.busy_out, bus.wr_en_out} !== 3'b100) begin n_errors++; $display("FAIL org_done_t5: got %b want 100", {bus.done_out, bus.busy_out, bus.wr_en_out}); end
    step(1);
    n_checks++; if (mem[0] !== 16'h8000) begin n_errors++; $display("FAIL org_mem0: got %h want 8000", mem[0]); end
    n_checks++; if ((n_wr - w0) !== 1 || (n_done - d0) !== 1) begin n_errors++; $display("FAIL org_counts: got wr=%0d done=%0d want 1 1", n_wr - w0, n_done - d0); end
  endtask

  task automatic test_toggle_word9;
    fill(0);
    poke(9, 16'hFFFF);
    issue(1'b1, 1'b0, 21, 2);
    n_checks++; if (bus.addr_r_out !== 8'd9) begin n_errors++; $display("FAIL w9_addr_r: got %h want 09", bus.addr_r_out); end
    step(3);
    n_checks++; if ({bus.wr_en_out, bus.addr_w_out, bus.data_w_out} !== {1'b1, 8'd9, 16'hFBFF}) begin
      n_errors++; $display("FAIL w9_write1: got wr=%b a=%h d=%h want wr=1 a=09 d=fbff", bus.wr_en_out, bus.addr_w_out, bus.data_w_out); end
    step(2);
    n_checks++; if (mem[9] !== 16'hFBFF) begin n_errors++; $display("FAIL w9_mem1: got %h want fbff", mem[9]); end
    issue(1'b1, 1'b0, 21, 2);
    step(3);
    n_checks++; if ({bus.wr_en_out, bus.addr_w_out, bus.data_w_out} !== {1'b1, 8'd9, 16'hFFFF}) begin
      n_errors++; $display("FAIL w9_write2: got wr=%b a=%h d=%h want wr=1 a=09 d=ffff", bus.wr_en_out, bus.addr_w_out, bus.data_w_out); end
    step(2);
    n_checks++; if (mem[9] !== 16'hFFFF) begin n_errors++; $display("FAIL w9_mem2: got %h want ffff", mem[9]); end
  endtask

  task automatic test_clear;
    int w0, nz;
    fill(1);
    w0 = n_wr;
    issue(1'b0, 1'b1, 0, 0);
    for (int k = 1; k <= NW; k++) begin
      n_checks++;
      if ({bus.busy_out, bus.wr_en_out, bus.addr_w_out, bus.data_w_out} !== {1'b1, 1'b1, addr_t'(k - 1), 16'h0}) begin
        n_errors++; $display("FAIL clr_seq%0d: got busy=%b wr=%b a=%h d=%h want busy=1 wr=1 a=%h d=0000", k, bus.busy_out, bus.wr_en_out, bus.addr_w_out, bus.data_w_out, addr_t'(k - 1)); end
      step(1);
    end
    n_checks++; if ({bus.done_out, bus.busy_out, bus.wr_en_out} !== 3'b100) begin n_errors++; $display("FAIL clr_done: got %b want 100", {bus.done_out, bus.busy_out, bus.wr_en_out}); end
    step(1);
    nz = 0;
    for (int i = 0; i < NW; i++) if (mem[i] !== 16'h0) nz++;
    n_checks++; if (nz !== 0) begin n_errors++; $display("FAIL clr_mem: got %0d nonzero words want 0", nz); end
    n_checks++; if ((n_wr - w0) !== NW) begin n_errors++; $display("FAIL clr_nwr: got %0d want %0d", n_wr - w0, NW); end
  endtask

  task automatic test_priority_and_busy;
    int w0, d0;
    fill(0);
    w0 = n_wr; d0 = n_done;
    issue(1'b1, 1'b1, 5, 3);
    n_checks++; if (bus.addr_r_out !== 8'd9) begin n_errors++; $display("FAIL prio_no_read: got %h want 09", bus.addr_r_out); end
    n_checks++; if ({bus.wr_en_out, bus.addr_w_out} !== {1'b1, 8'd0}) begin n_errors++; $display("FAIL prio_clear: got wr=%b a=%h want wr=1 a=00", bus.wr_en_out, bus.addr_w_out); end
    step(8);
    issue(1'b1, 1'b0, 0, 0);
    step(9);
    issue(1'b0, 1'b1, 0, 0);
    step(237);
    n_checks++; if (bus.done_out !== 1'b1) begin n_errors++; $display("FAIL prio_done: got %b want 1", bus.done_out); end
    step(1);
    n_checks++; if (bus.busy_out !== 1'b0) begin n_errors++; $display("FAIL prio_idle: got %b want 0", bus.busy_out); end
    step(6);
    n_checks++; if ((n_wr - w0) !== NW || (n_done - d0) !== 1) begin n_errors++; $display("FAIL prio_counts: got wr=%0d done=%0d want %0d 1", n_wr - w0, n_done - d0, NW); end
    w0 = n_wr; d0 = n_done;
    issue(1'b1, 1'b0, 1, 0);
    issue(1'b1, 1'b0, 1, 0);
    step(9);
    n_checks++; if (mem[0] !== 16'h4000) begin n_errors++; $display("FAIL busy_tog_mem: got %h want 4000", mem[0]); end
    n_checks++; if ((n_wr - w0) !== 1 || (n_done - d0) !== 1) begin n_errors++; $display("FAIL busy_tog_counts: got wr=%0d done=%0d want 1 1", n_wr - w0, n_done - d0); end
  endtask

  task automatic test_cursor_latch;
    fill(0);
    issue(1'b1, 1'b0, 17, 1);
    bus.cursor_x_in = 6'd0;
    bus.cursor_y_in = 6'd63;
    step(1);
    bus.cursor_x_in = 6'd13;
    bus.cursor_y_in = 6'd40;
    step(2);
    n_checks++; if ({bus.wr_en_out, bus.addr_w_out, bus.data_w_out} !== {1'b1, 8'd5, 16'h4000}) begin
      n_errors++; $display("FAIL latch_write: got wr=%b a=%h d=%h want wr=1 a=05 d=4000", bus.wr_en_out, bus.addr_w_out, bus.data_w_out); end
    step(2);
    n_checks++; if (mem[5] !== 16'h4000 || mem[252] !== 16'h0) begin n_errors++; $display("FAIL latch_mem: got m5=%h m252=%h want 4000 0000", mem[5], mem[252]); end
  endtask

  task automatic test_reset_mid_clear;
    int bad_lo, bad_hi;
    fill(1);
    issue(1'b0, 1'b1, 0, 0);
    step(100);
    n_checks++; if ({bus.wr_en_out, bus.addr_w_out} !== {1'b1, 8'd100}) begin n_errors++; $display("FAIL mid_pre: got wr=%b a=%h want wr=1 a=64", bus.wr_en_out, bus.addr_w_out); end
    rst = 1'b1;
    #1;
    n_checks++; if (bus.wr_en_out !== 1'b0) begin n_errors++; $display("FAIL mid_async_wr: got %b want 0", bus.wr_en_out); end
    n_checks++; if ({bus.busy_out, bus.done_out, bus.addr_w_out, bus.addr_r_out, bus.data_w_out} !== '0) begin
      n_errors++; $display("FAIL mid_async_out: got busy=%b done=%b aw=%h ar=%h d=%h want all 0", bus.busy_out, bus.done_out, bus.addr_w_out, bus.addr_r_out, bus.data_w_out); end
    @(negedge clk);
    rst = 1'b0;
    step(2);
    bad_lo = 0; bad_hi = 0;
    for (int i = 0; i < 100; i++) if (mem[i] !== 16'h0) bad_lo++;
    for (int i = 100; i < NW; i++) if (mem[i] !== fill_val(1, i)) bad_hi++;
    n_checks++; if (bad_lo !== 0) begin n_errors++; $display("FAIL mid_cleared: got %0d bad words below 100 want 0", bad_lo); end
    n_checks++; if (bad_hi !== 0) begin n_errors++; $display("FAIL mid_untouched: got %0d changed words at or above 100 want 0", bad_hi); end
    n_checks++; if ({bus.busy_out, bus.wr_en_out} !== 2'b00) begin n_errors++; $display("FAIL mid_idle: got %b want 00", {bus.busy_out, bus.wr_en_out}); end
    issue(1'b1, 1'b0, 0, 0);
    step(3);
    n_checks++; if ({bus.wr_en_out, bus.addr_w_out, bus.data_w_out} !== {1'b1, 8'd0, 16'h8000}) begin
      n_errors++; $display("FAIL mid_toggle: got wr=%b a=%h d=%h want wr=1 a=00 d=8000", bus.wr_en_out, bus.addr_w_out, bus.data_w_out); end
    step(1);
    n_checks++; if (bus.done_out !== 1'b1) begin n_errors++; $display("FAIL mid_toggle_done: got %b want 1", bus.done_out); end
    step(2);
  endtask

  initial begin
    rst             = 1'b1;
    bus.toggle_in   = 1'b0;
    bus.clear_in    = 1'b0;
    bus.cursor_x_in = '0;
    bus.cursor_y_in = '0;
    test_reset();
    test_toggle_origin();
    test_toggle_word9();
    test_clear();
    test_priority_and_busy();
    test_cursor_latch();
    test_reset_mid_clear();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
